reg_wb_ctrl: RTL

REG_WB_CTRL -- requirements
Module: reg_wb_ctrl

---
 rtl/reg_wb_ctrl.sv | 137 +++++++++++++
 1 files changed

// File: rtl/reg_wb_ctrl.sv
// Register write-back controller: busy scoreboard for issue, plus a 2-entry in-order write queue shared by the LSU and ALU.
// Latency: a write-back accepted into an empty queue drives the register-file port in the next cycle. Busy bits update at the clock edge.
// Backpressure: iss_ready drops on a WAW hazard. lsu_ready and alu_ready follow queue space, and the LSU takes priority for the last free slot.
module reg_wb_ctrl #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  iss_valid,
    input  logic [4:0]            iss_rd,
    output logic                  iss_ready,
    input  logic                  alu_valid,
    input  logic [4:0]            alu_rd,
    input  logic [DATA_WIDTH-1:0] alu_data,
    output logic                  alu_ready,
    input  logic                  lsu_valid,
    input  logic [4:0]            lsu_rd,
    input  logic [DATA_WIDTH-1:0] lsu_data,
    output logic                  lsu_ready,
    input  logic [4:0]            q_rs1,
    input  logic [4:0]            q_rs2,
    output logic                  rs1_busy,
    output logic                  rs2_busy,
    output logic                  wr_en,
    output logic [4:0]            addr_wr,
    output logic [DATA_WIDTH-1:0] data_wr,
    output logic                  err
);

    typedef struct packed {
        logic [4:0]            rd;
        logic [DATA_WIDTH-1:0] data;
    } wb_ent_t;

    logic [31:0] r_busy;
    logic [1:0]  r_count;
    wb_ent_t     r_ent0;    // head of queue, also drives the write port
    wb_ent_t     r_ent1;
    logic        r_err;

    logic [2:0]  w_free;
    logic        w_lsu_acc;
    logic        w_alu_acc;
    logic        w_lsu_push;
    logic        w_alu_push;
    logic        w_pop;
    logic        w_iss_set;
    logic        w_lsu_queued;
    logic        w_alu_queued;
    logic        w_err_set;
    logic [31:0] w_busy_nxt;
    logic [1:0]  w_count_nxt;
    wb_ent_t     w_ent0_nxt;
    wb_ent_t     w_ent1_nxt;

    // The head always pops when the queue is non-empty, so its slot counts as free.
    assign w_free    = 3'd2 - {1'b0, r_count} + {2'b00, (r_count != 2'd0)};
    assign lsu_ready = (w_free >= 3'd1);
    assign alu_ready = (w_free >= 3'd2) || ((w_free >= 3'd1) && !lsu_valid);
    assign iss_ready = !((iss_rd != 5'd0) && r_busy[iss_rd]);

    assign w_lsu_acc  = lsu_valid && lsu_ready;
    assign w_alu_acc  = alu_valid && alu_ready;
    assign w_lsu_push = w_lsu_acc && (lsu_rd != 5'd0);
    assign w_alu_push = w_alu_acc && (alu_rd != 5'd0);
    assign w_pop      = (r_count != 2'd0);
    assign w_iss_set  = iss_valid && iss_ready && (iss_rd != 5'd0);

    assign w_lsu_queued = ((r_count != 2'd0) && (r_ent0.rd == lsu_rd)) ||
                          ((r_count == 2'd2) && (r_ent1.rd == lsu_rd));
    assign w_alu_queued = ((r_count != 2'd0) && (r_ent0.rd == alu_rd)) ||
                          ((r_count == 2'd2) && (r_ent1.rd == alu_rd));

    // A write-back to a register nobody reserved and that is not already pending is a protocol error.
    assign w_err_set = (w_lsu_push && !r_busy[lsu_rd] && !w_lsu_queued) ||
                       (w_alu_push && !r_busy[alu_rd] && !w_alu_queued);

    assign wr_en    = (r_count != 2'd0);
    assign addr_wr  = r_ent0.rd;
    assign data_wr  = r_ent0.data;
    assign err      = r_err;
    assign rs1_busy = r_busy[q_rs1];
    assign rs2_busy = r_busy[q_rs2];

    // Queue next state: pop the head first, then append the LSU entry, then the ALU entry.
    always_comb begin
        w_ent0_nxt  = (r_count == 2'd2) ? r_ent1 : r_ent0;
        w_ent1_nxt  = r_ent1;
        w_count_nxt = (r_count == 2'd2) ? 2'd1 : 2'd0;
        if (w_lsu_push) begin
            if (w_count_nxt == 2'd0) begin
                w_ent0_nxt = '{rd: lsu_rd, data: lsu_data};
            end else begin
                w_ent1_nxt = '{rd: lsu_rd, data: lsu_data};
            end
            w_count_nxt = w_count_nxt + 2'd1;
        end
        if (w_alu_push) begin
            if (w_count_nxt == 2'd0) begin
                w_ent0_nxt = '{rd: alu_rd, data: alu_data};
            end else begin
                w_ent1_nxt = '{rd: alu_rd, data: alu_data};
            end
            w_count_nxt = w_count_nxt + 2'd1;
        end
    end

    // Busy next state: clear on head pop, set on accepted reservation. x0 is never busy.
    always_comb begin
        w_busy_nxt = r_busy;
        if (w_pop) begin
            w_busy_nxt[r_ent0.rd] = 1'b0;
        end
        if (w_iss_set) begin
            w_busy_nxt[iss_rd] = 1'b1;
        end
        w_busy_nxt[0] = 1'b0;
    end

    // State registers. Reset discards any queued writes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_busy  <= '0;
            r_count <= 2'd0;
            r_ent0  <= '0;
            r_ent1  <= '0;
            r_err   <= 1'b0;
        end else begin
            r_busy  <= w_busy_nxt;
            r_count <= w_count_nxt;
            r_ent0  <= w_ent0_nxt;
            r_ent1  <= w_ent1_nxt;
            r_err   <= r_err | w_err_set;
        end
    end

endmodule
